// File: rtl/mtr_pkg.sv
// Shared constants, FSM encoding and small helpers for the motor ramp block.
package mtr_pkg;

  localparam int DUTY_W = 10;
  localparam int CMD_W  = 11;

  localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};

  // Per-channel ramp FSM encoding.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DECEL = 2'd1,
    ST_DEAD  = 2'd2
  } chan_state_e;

  // Magnitude of a signed command, saturated to the duty range (-1024 -> 1023).
  function automatic logic [DUTY_W-1:0] cmd_mag(input logic [CMD_W-1:0] cmd);
    logic [CMD_W-1:0] mag;
    mag = cmd[CMD_W-1] ? (~cmd + 11'd1) : cmd;
    if (mag[CMD_W-1]) begin
      return DUTY_MAX;
    end
    return mag[DUTY_W-1:0];
  endfunction

  // Clamp an 11-bit unsigned intermediate result into the 10-bit duty range.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W:0] v);
    if (v[DUTY_W]) begin
      return DUTY_MAX;
    end
    return v[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/mtr_chan.sv
// One motor channel: command target latch, RUN/DECEL/DEAD ramp FSM,
// duty ramp arithmetic and dead-time counter. Advances only on i_tick.
//
// Command handshake: i_cmd_vld is a single-cycle strobe with no ready; the
// command is always accepted. When the strobe coincides with i_tick the new
// command already governs that tick's update.
module mtr_chan
  import mtr_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP       = 10'd8,
  parameter int                DEAD_TICKS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tick,
  input  logic              i_cmd_vld,
  input  logic [CMD_W-1:0]  i_cmd,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_rev,
  output logic              o_busy,
  output chan_state_e       o_state
);

  localparam int              DC_W      = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [DC_W-1:0] DEAD_LAST = DC_W'(DEAD_TICKS - 1);
  localparam logic [DC_W-1:0] DC_ONE    = DC_W'(1);

  chan_state_e       r_state;
  logic [DUTY_W-1:0] r_duty;
  logic              r_rev;
  logic [DUTY_W-1:0] r_tgt_mag;
  logic              r_tgt_dir;
  logic [DC_W-1:0]   r_dead_cnt;

  chan_state_e       w_state_nxt;
  logic [DUTY_W-1:0] w_duty_nxt;
  logic              w_rev_nxt;
  logic [DC_W-1:0]   w_dead_nxt;

  logic [DUTY_W-1:0] w_cmd_mag;
  logic [DUTY_W-1:0] w_tgt_mag;
  logic              w_tgt_dir;
  logic              w_dir_match;
  logic [DUTY_W:0]   w_duty_x;
  logic [DUTY_W:0]   w_tgt_x;
  logic [DUTY_W:0]   w_step_x;
  logic [DUTY_W:0]   w_approach_x;
  logic [DUTY_W:0]   w_decel_x;
  logic [DUTY_W-1:0] w_duty_approach;
  logic [DUTY_W-1:0] w_duty_decel;

  assign w_cmd_mag = cmd_mag(i_cmd);

  // A strobe in this cycle overrides the held target so it can govern a coincident tick.
  assign w_tgt_mag = i_cmd_vld ? w_cmd_mag : r_tgt_mag;
  assign w_tgt_dir = i_cmd_vld ? i_cmd[CMD_W-1] : r_tgt_dir;

  // A zero target never asks for a reversal.
  assign w_dir_match = (w_tgt_mag == '0) || (w_tgt_dir == r_rev);

  assign w_duty_x = {1'b0, r_duty};
  assign w_tgt_x  = {1'b0, w_tgt_mag};
  assign w_step_x = {1'b0, STEP};

  // Step toward the target by at most STEP, landing exactly on it when close.
  always_comb begin
    w_approach_x = w_tgt_x;
    if (w_tgt_x >= w_duty_x) begin
      if ((w_tgt_x - w_duty_x) > w_step_x) begin
        w_approach_x = w_duty_x + w_step_x;
      end
    end else begin
      if ((w_duty_x - w_tgt_x) > w_step_x) begin
        w_approach_x = w_duty_x - w_step_x;
      end
    end
  end

  // Step toward zero by at most STEP.
  always_comb begin
    w_decel_x = '0;
    if (w_duty_x > w_step_x) begin
      w_decel_x = w_duty_x - w_step_x;
    end
  end

  assign w_duty_approach = clamp_duty(w_approach_x);
  assign w_duty_decel    = clamp_duty(w_decel_x);

  // Hold the most recent command as the channel target.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tgt_mag <= '0;
      r_tgt_dir <= 1'b0;
    end else if (i_cmd_vld) begin
      r_tgt_mag <= w_cmd_mag;
      r_tgt_dir <= i_cmd[CMD_W-1];
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; transitions happen only on a ramp tick.
  always_comb begin
    w_state_nxt = r_state;
    if (i_tick) begin
      case (r_state)
        ST_RUN: begin
          if (!w_dir_match) w_state_nxt = ST_DECEL;
        end
        ST_DECEL: begin
          if (w_dir_match)              w_state_nxt = ST_RUN;
          else if (w_duty_decel == '0)  w_state_nxt = ST_DEAD;
        end
        ST_DEAD: begin
          if (w_dir_match)                  w_state_nxt = ST_RUN;
          else if (r_dead_cnt == DEAD_LAST) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Datapath next values (duty, direction, dead counter) per FSM state.
  always_comb begin
    w_duty_nxt = r_duty;
    w_rev_nxt  = r_rev;
    w_dead_nxt = r_dead_cnt;
    if (i_tick) begin
      case (r_state)
        ST_RUN: begin
          w_dead_nxt = '0;
          if (w_dir_match) w_duty_nxt = w_duty_approach;
        end
        ST_DECEL: begin
          w_dead_nxt = '0;
          if (!w_dir_match) w_duty_nxt = w_duty_decel;
        end
        ST_DEAD: begin
          if (w_dir_match) begin
            w_dead_nxt = '0;
          end else if (r_dead_cnt == DEAD_LAST) begin
            w_dead_nxt = '0;
            w_rev_nxt  = ~r_rev;
          end else begin
            w_dead_nxt = r_dead_cnt + DC_ONE;
          end
        end
        default: begin
          w_dead_nxt = '0;
        end
      endcase
    end
  end

  // Registered duty, direction and dead-time counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty     <= '0;
      r_rev      <= 1'b0;
      r_dead_cnt <= '0;
    end else begin
      r_duty     <= w_duty_nxt;
      r_rev      <= w_rev_nxt;
      r_dead_cnt <= w_dead_nxt;
    end
  end

  assign o_duty  = r_duty;
  assign o_rev   = r_rev;
  assign o_state = r_state;

  // Busy is derived from registered state only, never from the live command.
  assign o_busy = (r_state != ST_RUN) ||
                  (r_duty != r_tgt_mag) ||
                  !((r_tgt_mag == '0) || (r_tgt_dir == r_rev));

endmodule

// File: rtl/mtr_ramp.sv
// Two-channel motor duty ramp: shared ramp-tick prescaler driving a left and a
// right channel that slew duty, enforce dead time on reversal and report busy.
module mtr_ramp
  import mtr_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP       = 10'd8,
  parameter int                TICK_DIV   = 1024,
  parameter int                DEAD_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  lft_cmd,
  input  logic [CMD_W-1:0]  rht_cmd,
  input  logic              cmd_vld,
  output logic [DUTY_W-1:0] lft_duty,
  output logic [DUTY_W-1:0] rht_duty,
  output logic              lft_rev,
  output logic              rht_rev,
  output logic              busy,
  output chan_state_e       lft_state,
  output chan_state_e       rht_state
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE   = PW'(1);

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic          w_lft_busy;
  logic          w_rht_busy;

  // The tick fires on the TICK_DIV-th clock after reset release.
  assign w_tick = (r_presc == PRE_LAST);

  // Free-running prescaler shared by both channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRE_ONE;
    end
  end

  mtr_chan #(
    .STEP       (STEP),
    .DEAD_TICKS (DEAD_TICKS)
  ) u_lft (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_tick    (w_tick),
    .i_cmd_vld (cmd_vld),
    .i_cmd     (lft_cmd),
    .o_duty    (lft_duty),
    .o_rev     (lft_rev),
    .o_busy    (w_lft_busy),
    .o_state   (lft_state)
  );

  mtr_chan #(
    .STEP       (STEP),
    .DEAD_TICKS (DEAD_TICKS)
  ) u_rht (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_tick    (w_tick),
    .i_cmd_vld (cmd_vld),
    .i_cmd     (rht_cmd),
    .o_duty    (rht_duty),
    .o_rev     (rht_rev),
    .o_busy    (w_rht_busy),
    .o_state   (rht_state)
  );

  assign busy = w_lft_busy | w_rht_busy;

endmodule
